// File: rtl/sram_responder_pkg.sv
// Shared word/lane definitions and the byte-lane merge used by the SRAM responder.
package sram_responder_pkg;

    localparam int DATA_W = 32;
    localparam int LANES  = 4;
    localparam int LANE_W = DATA_W / LANES;

    typedef logic [DATA_W-1:0] word_t;
    typedef logic [LANES-1:0]  lane_en_t;

    // Replace the lanes of old_w selected by wen with the same lanes of new_w.
    function automatic word_t merge_bytes(input word_t old_w, input word_t new_w,
                                          input lane_en_t wen);
        word_t merged;
        merged = old_w;
        for (int i = 0; i < LANES; i++) begin
            if (wen[i]) begin
                merged[i*LANE_W +: LANE_W] = new_w[i*LANE_W +: LANE_W];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/sram_port_ctrl.sv
// One access port: byte address to word index, error decode and the
// registered read-data output.
module sram_port_ctrl
    import sram_responder_pkg::*;
#(
    parameter int AW      = 16,
    parameter int ERR_CHK = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en_i,
    input  logic [31:0]   addr_i,
    input  word_t         mem_word_i,
    output logic [AW-1:0] idx_o,
    output logic          err_o,
    output word_t         rdata_o
);

    logic  misaligned;
    logic  out_of_range;
    word_t rdata_q;

    // Low two bits select a byte inside the word and never take part in indexing.
    assign idx_o        = addr_i[AW+1:2];
    assign misaligned   = (addr_i[1:0] != 2'b00);
    assign out_of_range = ((addr_i >> (AW + 2)) != 32'd0);
    assign err_o        = (ERR_CHK != 0) && en_i && (misaligned || out_of_range);

    // Capture the addressed word one cycle after a request; hold it otherwise.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_q <= '0;
        end else if (en_i) begin
            rdata_q <= mem_word_i;
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/sram_responder.sv
// Dual-port word SRAM responder: read-only instruction port, byte-writable
// data port, 1-cycle read latency and a sticky access-error recorder.
module sram_responder
    import sram_responder_pkg::*;
#(
    parameter int AW      = 16,
    parameter int ERR_CHK = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inst_sram_en,
    input  logic [3:0]  inst_sram_wen,
    input  logic [31:0] inst_sram_addr,
    input  logic [31:0] inst_sram_wdata,
    output logic [31:0] inst_sram_rdata,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_wen,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    output logic        err,
    output logic [31:0] err_addr
);

    localparam int DEPTH = 1 << AW;

    word_t          mem_q [DEPTH];
    logic [AW-1:0]  inst_idx;
    logic [AW-1:0]  data_idx;
    logic           inst_err;
    logic           data_err;
    word_t          inst_word;
    word_t          data_word;
    word_t          merged_word;
    logic           data_wr;
    logic           err_q;
    logic           err_d;
    logic [31:0]    err_addr_q;
    logic [31:0]    err_addr_d;
    logic           unused_inst_write;

    // The instruction port is read-only; its write inputs are deliberately dropped.
    assign unused_inst_write = ^{inst_sram_wen, inst_sram_wdata};

    sram_port_ctrl #(.AW(AW), .ERR_CHK(ERR_CHK)) u_inst_port (
        .clk        (clk),
        .reset      (reset),
        .en_i       (inst_sram_en),
        .addr_i     (inst_sram_addr),
        .mem_word_i (inst_word),
        .idx_o      (inst_idx),
        .err_o      (inst_err),
        .rdata_o    (inst_sram_rdata)
    );

    sram_port_ctrl #(.AW(AW), .ERR_CHK(ERR_CHK)) u_data_port (
        .clk        (clk),
        .reset      (reset),
        .en_i       (data_sram_en),
        .addr_i     (data_sram_addr),
        .mem_word_i (data_word),
        .idx_o      (data_idx),
        .err_o      (data_err),
        .rdata_o    (data_sram_rdata)
    );

    // A write happens only for a clean, enabled data access outside reset.
    assign data_wr     = data_sram_en && (data_sram_wen != 4'b0000) && !data_err && !reset;
    assign merged_word = merge_bytes(mem_q[data_idx], data_sram_wdata, data_sram_wen);

    // Data port is read-first; the instruction port sees a same-index write merged in.
    assign data_word = mem_q[data_idx];
    assign inst_word = (data_wr && (data_idx == inst_idx)) ? merged_word : mem_q[inst_idx];

    // Storage update for enabled byte lanes.
    // NOTE: storage is intentionally not reset, so contents survive reset and map onto plain RAM.
    always_ff @(posedge clk) begin
        if (data_wr) begin
            mem_q[data_idx] <= merged_word;
        end
    end

    // First-error capture: data port wins a same-cycle tie; later errors are ignored.
    // NOTE: next-state signals get a default first so no path leaves them unassigned (no latch).
    always_comb begin
        err_d      = err_q;
        err_addr_d = err_addr_q;
        if (!err_q) begin
            if (data_err) begin
                err_d      = 1'b1;
                err_addr_d = data_sram_addr;
            end else if (inst_err) begin
                err_d      = 1'b1;
                err_addr_d = inst_sram_addr;
            end
        end
    end

    // Sticky error flag and address, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_q      <= 1'b0;
            err_addr_q <= '0;
        end else begin
            err_q      <= err_d;
            err_addr_q <= err_addr_d;
        end
    end

    assign err      = err_q;
    assign err_addr = err_addr_q;

endmodule

// File: tb/tb_sram_responder.sv
// Self-checking bench for sram_responder: directed scenarios plus randomized
// traffic compared against a word-array reference model.
module tb_sram_responder;

    localparam int AW  = 16;
    localparam int NAW = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        inst_sram_en = 1'b0;
    logic [3:0]  inst_sram_wen = '0;
    logic [31:0] inst_sram_addr = '0;
    logic [31:0] inst_sram_wdata = '0;
    logic [31:0] inst_sram_rdata;
    logic        data_sram_en = 1'b0;
    logic [3:0]  data_sram_wen = '0;
    logic [31:0] data_sram_addr = '0;
    logic [31:0] data_sram_wdata = '0;
    logic [31:0] data_sram_rdata;
    logic        err;
    logic [31:0] err_addr;

    // Second instance with error checking disabled and a small array.
    logic        n_reset = 1'b1;
    logic        n_inst_en = 1'b0;
    logic [31:0] n_inst_addr = '0;
    logic [31:0] n_inst_rdata;
    logic        n_data_en = 1'b0;
    logic [3:0]  n_data_wen = '0;
    logic [31:0] n_data_addr = '0;
    logic [31:0] n_data_wdata = '0;
    logic [31:0] n_data_rdata;
    logic        n_err;
    logic [31:0] n_err_addr;

    int checks = 0;
    int errors = 0;

    // Reference model state.
    logic [31:0] mdl_mem [int];
    logic [31:0] exp_i;
    logic [31:0] exp_d;
    logic        exp_err;
    logic [31:0] exp_err_addr;
    int          pool [8] = '{0, 1, 2, 3, 100, 101, 16'h7FFF, 16'hFFFF};

    always #5 clk = ~clk;

    sram_responder #(.AW(AW), .ERR_CHK(1)) u_dut (
        .clk             (clk),
        .reset           (reset),
        .inst_sram_en    (inst_sram_en),
        .inst_sram_wen   (inst_sram_wen),
        .inst_sram_addr  (inst_sram_addr),
        .inst_sram_wdata (inst_sram_wdata),
        .inst_sram_rdata (inst_sram_rdata),
        .data_sram_en    (data_sram_en),
        .data_sram_wen   (data_sram_wen),
        .data_sram_addr  (data_sram_addr),
        .data_sram_wdata (data_sram_wdata),
        .data_sram_rdata (data_sram_rdata),
        .err             (err),
        .err_addr        (err_addr)
    );

    sram_responder #(.AW(NAW), .ERR_CHK(0)) u_dut_nochk (
        .clk             (clk),
        .reset           (n_reset),
        .inst_sram_en    (n_inst_en),
        .inst_sram_wen   (4'hF),
        .inst_sram_addr  (n_inst_addr),
        .inst_sram_wdata (32'hFFFF_FFFF),
        .inst_sram_rdata (n_inst_rdata),
        .data_sram_en    (n_data_en),
        .data_sram_wen   (n_data_wen),
        .data_sram_addr  (n_data_addr),
        .data_sram_wdata (n_data_wdata),
        .data_sram_rdata (n_data_rdata),
        .err             (n_err),
        .err_addr        (n_err_addr)
    );

    function automatic logic [31:0] lane_merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                               input logic [3:0] wen);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) begin
            r[8*b +: 8] = wen[b] ? new_w[8*b +: 8] : old_w[8*b +: 8];
        end
        return r;
    endfunction

    function automatic bit bad_addr(input logic [31:0] a);
        return ((a % 4) != 0) || (a >= (32'd4 << AW));
    endfunction

    function automatic int word_of(input logic [31:0] a);
        return int'((a / 4) % (32'd1 << AW));
    endfunction

    function automatic logic [31:0] mdl_get(input int idx);
        if (mdl_mem.exists(idx)) return mdl_mem[idx];
        return 32'hxxxx_xxxx;
    endfunction

    // Drive one cycle on the main DUT, advance the model, sample 1 time unit after the edge.
    task automatic step(input bit rst, input bit ie, input logic [31:0] ia,
                        input bit de, input logic [3:0] dw, input logic [31:0] da,
                        input logic [31:0] dd);
        bit          d_bad;
        bit          i_bad;
        bit          wr;
        int          di;
        int          ii;
        logic [31:0] old_d;
        logic [31:0] new_d;
        reset           = rst;
        inst_sram_en    = ie;
        inst_sram_addr  = ia;
        inst_sram_wen   = 4'($urandom);
        inst_sram_wdata = $urandom;
        data_sram_en    = de;
        data_sram_wen   = dw;
        data_sram_addr  = da;
        data_sram_wdata = dd;
        if (rst) begin
            exp_i        = '0;
            exp_d        = '0;
            exp_err      = 1'b0;
            exp_err_addr = '0;
        end else begin
            d_bad = de && bad_addr(da);
            i_bad = ie && bad_addr(ia);
            di    = word_of(da);
            ii    = word_of(ia);
            old_d = mdl_get(di);
            wr    = de && (dw != 4'b0000) && !d_bad;
            new_d = lane_merge(old_d, dd, dw);
            if (ie) exp_i = (wr && ii == di) ? new_d : mdl_get(ii);
            if (de) exp_d = old_d;
            if (wr) mdl_mem[di] = new_d;
            if (!exp_err && (d_bad || i_bad)) begin
                exp_err      = 1'b1;
                exp_err_addr = d_bad ? da : ia;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, $urandom, 1'b0, 4'($urandom), $urandom, $urandom);
    endtask

    task automatic test_reset();
        step(1'b1, 1'b0, 0, 1'b0, 0, 0, 0);
        step(1'b1, 1'b0, 0, 1'b0, 0, 0, 0);
        checks += 4;
        if (inst_sram_rdata !== 32'h0) begin errors++; $display("FAIL reset_inst_rdata got %h want 0", inst_sram_rdata); end
        if (data_sram_rdata !== 32'h0) begin errors++; $display("FAIL reset_data_rdata got %h want 0", data_sram_rdata); end
        if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", err); end
        if (err_addr !== 32'h0) begin errors++; $display("FAIL reset_err_addr got %h want 0", err_addr); end
    endtask

    task automatic test_write_read();
        step(1'b0, 1'b0, 0, 1'b1, 4'hF, 32'h10, 32'hDEAD_BEEF);
        step(1'b0, 1'b0, 0, 1'b1, 4'h0, 32'h10, 32'h0);
        checks++;
        if (data_sram_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL full_write_read got %h want deadbeef", data_sram_rdata); end
        step(1'b0, 1'b0, 0, 1'b1, 4'b0101, 32'h10, 32'h1122_3344);
        step(1'b0, 1'b1, 32'h10, 1'b1, 4'h0, 32'h10, 32'h0);
        checks += 2;
        if (data_sram_rdata !== 32'hDE22_BE44) begin errors++; $display("FAIL lane_write_data got %h want de22be44", data_sram_rdata); end
        if (inst_sram_rdata !== 32'hDE22_BE44) begin errors++; $display("FAIL lane_write_inst got %h want de22be44", inst_sram_rdata); end
    endtask

    task automatic test_forward();
        step(1'b0, 1'b0, 0, 1'b1, 4'hF, 32'h20, 32'h0102_0304);
        step(1'b0, 1'b1, 32'h20, 1'b1, 4'hF, 32'h20, 32'hCAFE_F00D);
        checks += 2;
        if (inst_sram_rdata !== 32'hCAFE_F00D) begin errors++; $display("FAIL fwd_inst got %h want cafef00d", inst_sram_rdata); end
        if (data_sram_rdata !== 32'h0102_0304) begin errors++; $display("FAIL fwd_data_readfirst got %h want 01020304", data_sram_rdata); end
    endtask

    task automatic test_error();
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL err_before got %b want 0", err); end
        step(1'b0, 1'b0, 0, 1'b1, 4'hF, 32'h22, 32'hFFFF_FFFF);
        checks += 3;
        if (err !== 1'b1) begin errors++; $display("FAIL err_rise got %b want 1", err); end
        if (err_addr !== 32'h22) begin errors++; $display("FAIL err_addr_first got %h want 00000022", err_addr); end
        if (data_sram_rdata !== 32'hCAFE_F00D) begin errors++; $display("FAIL err_trunc_read got %h want cafef00d", data_sram_rdata); end
        step(1'b0, 1'b0, 0, 1'b1, 4'h0, 32'h20, 32'h0);
        checks++;
        if (data_sram_rdata !== 32'hCAFE_F00D) begin errors++; $display("FAIL err_write_dropped got %h want cafef00d", data_sram_rdata); end
        step(1'b0, 1'b1, 32'h8000_0000, 1'b0, 0, 0, 0);
        checks += 2;
        if (err !== 1'b1) begin errors++; $display("FAIL err_sticky got %b want 1", err); end
        if (err_addr !== 32'h22) begin errors++; $display("FAIL err_addr_kept got %h want 00000022", err_addr); end
    endtask

    task automatic test_hold_reset();
        step(1'b0, 1'b0, 0, 1'b1, 4'h0, 32'h10, 32'h0);
        for (int k = 0; k < 5; k++) begin
            step(1'b0, 1'b0, $urandom, 1'b0, 4'hF, 32'h10, $urandom);
            checks++;
            if (data_sram_rdata !== 32'hDE22_BE44) begin errors++; $display("FAIL hold_cycle%0d got %h want de22be44", k, data_sram_rdata); end
        end
        step(1'b0, 1'b1, 32'h20, 1'b1, 4'h0, 32'h20, 32'h0);
        checks++;
        if (inst_sram_rdata !== 32'hCAFE_F00D) begin errors++; $display("FAIL pre_reset_read got %h want cafef00d", inst_sram_rdata); end
        step(1'b1, 1'b1, 32'h10, 1'b1, 4'hF, 32'h10, 32'hBAD0_BAD0);
        checks += 4;
        if (inst_sram_rdata !== 32'h0) begin errors++; $display("FAIL rst_inst_rdata got %h want 0", inst_sram_rdata); end
        if (data_sram_rdata !== 32'h0) begin errors++; $display("FAIL rst_data_rdata got %h want 0", data_sram_rdata); end
        if (err !== 1'b0) begin errors++; $display("FAIL rst_err got %b want 0", err); end
        if (err_addr !== 32'h0) begin errors++; $display("FAIL rst_err_addr got %h want 0", err_addr); end
        step(1'b0, 1'b1, 32'h10, 1'b1, 4'h0, 32'h10, 32'h0);
        checks += 2;
        if (data_sram_rdata !== 32'hDE22_BE44) begin errors++; $display("FAIL post_reset_data got %h want de22be44", data_sram_rdata); end
        if (inst_sram_rdata !== 32'hDE22_BE44) begin errors++; $display("FAIL post_reset_inst got %h want de22be44", inst_sram_rdata); end
    endtask

    task automatic test_both_err();
        step(1'b0, 1'b1, 32'h101, 1'b1, 4'hF, 32'h202, 32'h1234_5678);
        checks += 2;
        if (err !== 1'b1) begin errors++; $display("FAIL both_err_flag got %b want 1", err); end
        if (err_addr !== 32'h202) begin errors++; $display("FAIL both_err_addr got %h want 00000202", err_addr); end
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        int          r;
        a = 32'(pool[$urandom_range(0, 7)]) * 4;
        r = $urandom_range(0, 15);
        if (r == 0) a = a + 32'($urandom_range(1, 3));
        if (r == 1) a = a | (32'd1 << $urandom_range(AW + 2, 31));
        return a;
    endfunction

    task automatic test_random();
        step(1'b1, 1'b0, 0, 1'b0, 0, 0, 0);
        foreach (pool[p]) step(1'b0, 1'b0, 0, 1'b1, 4'hF, 32'(pool[p]) * 4, $urandom);
        for (int c = 0; c < 400; c++) begin
            step($urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0, rand_addr(),
                 $urandom_range(0, 3) != 0, 4'($urandom), rand_addr(), $urandom);
            if (!$isunknown(exp_d)) begin
                checks++;
                if (data_sram_rdata !== exp_d) begin errors++; $display("FAIL rand_data_rdata cyc %0d got %h want %h", c, data_sram_rdata, exp_d); end
            end
            if (!$isunknown(exp_i)) begin
                checks++;
                if (inst_sram_rdata !== exp_i) begin errors++; $display("FAIL rand_inst_rdata cyc %0d got %h want %h", c, inst_sram_rdata, exp_i); end
            end
            checks += 2;
            if (err !== exp_err) begin errors++; $display("FAIL rand_err cyc %0d got %b want %b", c, err, exp_err); end
            if (err_addr !== exp_err_addr) begin errors++; $display("FAIL rand_err_addr cyc %0d got %h want %h", c, err_addr, exp_err_addr); end
        end
    endtask

    task automatic n_step(input bit rst, input bit de, input logic [3:0] dw,
                          input logic [31:0] da, input logic [31:0] dd,
                          input bit ie, input logic [31:0] ia);
        n_reset      = rst;
        n_data_en    = de;
        n_data_wen   = dw;
        n_data_addr  = da;
        n_data_wdata = dd;
        n_inst_en    = ie;
        n_inst_addr  = ia;
        @(posedge clk);
        #1;
    endtask

    task automatic test_no_errchk();
        n_step(1'b1, 1'b0, 0, 0, 0, 1'b0, 0);
        n_step(1'b0, 1'b1, 4'hF, 32'h22, 32'h5A5A_1234, 1'b0, 0);
        checks += 2;
        if (n_err !== 1'b0) begin errors++; $display("FAIL nochk_err got %b want 0", n_err); end
        if (n_err_addr !== 32'h0) begin errors++; $display("FAIL nochk_err_addr got %h want 0", n_err_addr); end
        n_step(1'b0, 1'b1, 4'h0, 32'h20, 0, 1'b1, 32'h20);
        checks += 2;
        if (n_data_rdata !== 32'h5A5A_1234) begin errors++; $display("FAIL nochk_misaligned_write got %h want 5a5a1234", n_data_rdata); end
        if (n_inst_rdata !== 32'h5A5A_1234) begin errors++; $display("FAIL nochk_inst_read got %h want 5a5a1234", n_inst_rdata); end
        n_step(1'b0, 1'b1, 4'b0011, 32'h8000_0020, 32'h0000_BBCC, 1'b0, 0);
        n_step(1'b0, 1'b1, 4'h0, 32'h20, 0, 1'b0, 0);
        checks += 3;
        if (n_data_rdata !== 32'h5A5A_BBCC) begin errors++; $display("FAIL nochk_oor_write got %h want 5a5abbcc", n_data_rdata); end
        if (n_err !== 1'b0) begin errors++; $display("FAIL nochk_err_late got %b want 0", n_err); end
        if (n_err_addr !== 32'h0) begin errors++; $display("FAIL nochk_err_addr_late got %h want 0", n_err_addr); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_forward();
        test_error();
        test_hold_reset();
        test_both_err();
        test_random();
        test_no_errchk();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sram_responder.md
SRAM_RESPONDER -- requirements
Module: sram_responder

Interface
REQ-001 SHALL have parameter AW, default 16, meaning word-index width; storage is 2^AW 32-bit words.
REQ-002 SHALL have parameter ERR_CHK, default 1, meaning enable of misaligned/out-of-range error detection.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port inst_sram_en  input  1  instruction-port access request.
REQ-006 SHALL have port inst_sram_wen  input  4  instruction-port byte write enables; ignored, the port is read-only.
REQ-007 SHALL have port inst_sram_addr  input  32  instruction-port byte address.
REQ-008 SHALL have port inst_sram_wdata  input  32  instruction-port write data; ignored.
REQ-009 SHALL have port inst_sram_rdata  output  32  instruction-port read data.
REQ-010 SHALL have port data_sram_en  input  1  data-port access request.
REQ-011 SHALL have port data_sram_wen  input  4  data-port byte write enables; bit i covers bits 8i+7:8i.
REQ-012 SHALL have port data_sram_addr  input  32  data-port byte address.
REQ-013 SHALL have port data_sram_wdata  input  32  data-port write data.
REQ-014 SHALL have port data_sram_rdata  output  32  data-port read data.
REQ-015 SHALL have port err  output  1  sticky access-error flag.
REQ-016 SHALL have port err_addr  output  32  byte address of the first erroneous access.

Function
REQ-017 Word index SHALL be addr[AW+1:2]; addr[1:0] are not used for indexing.
REQ-018 Read latency SHALL be exactly 1 cycle: en=1 in cycle N puts the indexed word on rdata in cycle N+1.
REQ-019 rdata SHALL hold its last value in any cycle after en=0; no spurious updates.
REQ-020 Data-port write: en=1 with wen!=0 SHALL update only the enabled byte lanes at the clock edge.
REQ-021 Data-port write SHALL be read-first: data_sram_rdata in cycle N+1 returns the word as it was before the write.
REQ-022 en=0 SHALL suppress writes regardless of wen.
REQ-023 Same-cycle data-port write and inst-port read of the same index SHALL be write-first for the inst port: inst_sram_rdata returns the merged new word.
REQ-024 Different indices on the two ports SHALL proceed independently with no stall; the block has no back-pressure.
REQ-025 With ERR_CHK=1, an access with en=1 and addr[1:0]!=0 SHALL be flagged as an error.
REQ-026 With ERR_CHK=1, an access with en=1 and any addr[31:AW+2] bit set SHALL be flagged as an error.
REQ-027 An erroneous data-port write SHALL be dropped; an erroneous read SHALL still return the word at the truncated index.
REQ-028 err SHALL rise one cycle after the first erroneous access and stay high until reset.
REQ-029 err_addr SHALL capture the address of the first erroneous access only.
REQ-030 If both ports err in the same cycle, err_addr SHALL capture the data-port address.
REQ-031 With ERR_CHK=0, err SHALL stay 0, err_addr SHALL stay 0, and no write is dropped.

Reset
REQ-032 During reset, inst_sram_rdata, data_sram_rdata, err and err_addr SHALL be 0 on the next edge.
REQ-033 Reset SHALL NOT clear storage contents.
REQ-034 Accesses presented in a reset cycle SHALL be ignored, including writes.
REQ-035 A read issued the cycle before reset asserts SHALL have its result overridden by the reset value.

Structure
REQ-036 A shared package SHALL hold the data width (32), byte-lane count (4) and a byte-merge function (old, new, wen) -> word.
REQ-037 The block SHALL have one sub-module, sram_port_ctrl, instantiated once per port.
REQ-038 sram_port_ctrl SHALL implement the index/error decode and the rdata register.
REQ-039 Storage and same-index forwarding SHALL reside in the top module.

Verification
REQ-040 Data write addr 0x10, wen=4'hF, wdata 0xDEADBEEF; next cycle read 0x10 -> data_sram_rdata=0xDEADBEEF one cycle later.
REQ-041 Starting from 0xDEADBEEF at 0x10, write wen=4'b0101, wdata 0x11223344; then read -> 0xDE22BE44.
REQ-042 Same cycle: data write 0x20 = 0xCAFEF00D and inst read 0x20 -> inst_sram_rdata=0xCAFEF00D; data_sram_rdata returns the prior word.
REQ-043 Data write to 0x22 -> word unchanged; err=1 next cycle; err_addr=0x22. A later error at 0x80000000 leaves err_addr=0x22.
REQ-044 Read 0x10, then en=0 for 5 cycles -> rdata held; assert reset -> all outputs 0; a re-read of 0x10 returns the pre-reset contents.
